pio_poll_master: RTL
====================

PIO_POLL_MASTER -- requirements
Module: pio_poll_master

Interface
REQ-001 SHALL have parameter DATA_W, default 4: width of the polled input field, range 1..32.
REQ-002 SHALL have parameter POLL_DIV, default 1000: clk cycles between automatic polls, minimum 2.
REQ-003 SHALL have parameter READ_LATENCY, default 1: fixed slave read latency in cycles, range 1..4.
REQ-004 SHALL have parameter POLL_ADDR, default 0: word address driven during a poll.
REQ-005 SHALL have clk input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have reset_n input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have enable input, 1 bit: permits automatic polling.
REQ-008 SHALL have poll_now input, 1 bit: single-cycle request for an immediate poll.
REQ-009 SHALL have address output, 2 bits: Avalon-MM master address.
REQ-010 SHALL have read output, 1 bit: Avalon-MM master read strobe.
REQ-011 SHALL have waitrequest input, 1 bit: slave stall; tie it to 0 for a slave without stall.
REQ-012 SHALL have readdata input, 32 bits: slave read data.
REQ-013 SHALL have value output, DATA_W bits: last accepted sample.
REQ-014 SHALL have valid output, 1 bit: value holds at least one accepted sample.
REQ-015 SHALL have changed output, 1 bit: one-cycle pulse when value updates.
REQ-016 SHALL have busy output, 1 bit: high in any state other than IDLE.

Function
REQ-017 SHALL implement the FSM states IDLE, REQ, WAIT and CAPTURE.
REQ-018 SHALL run a divider counter of POLL_DIV cycles while enable=1; the counter freezes when enable=0.
- Terminal count in IDLE: go to REQ and reload the counter.
REQ-019 SHALL handle poll_now in IDLE by going to REQ on the next edge and reloading the divider.
REQ-020 SHALL latch poll_now asserted outside IDLE into a single pending flag.
- On return to IDLE with the flag set: go to REQ, clear the flag.
- Multiple requests collapse into one.
REQ-021 SHALL drive read=1 and address=POLL_ADDR in REQ; outside REQ, read=0 and address=0.
REQ-022 SHALL hold read, address and state in REQ while waitrequest=1.
- Acceptance is the edge with read=1 and waitrequest=0; the FSM then moves to WAIT.
REQ-023 SHALL stay in WAIT for READ_LATENCY-1 cycles, then move to CAPTURE.
- CAPTURE samples readdata[DATA_W-1:0] exactly READ_LATENCY cycles after acceptance.
REQ-024 SHALL ignore readdata bits above DATA_W-1.
REQ-025 SHALL, in CAPTURE, load value, set valid and pulse changed for one cycle when either condition holds:
- the sample differs from value;
- valid=0.
REQ-026 SHALL return from CAPTURE to IDLE unconditionally.
REQ-027 SHALL complete an in-flight transaction when enable falls mid-poll; enable affects only new automatic polls.
REQ-028 SHALL give poll_now priority when it coincides with divider terminal count; exactly one poll results.
REQ-029 SHALL give a minimum poll-to-poll spacing of 3+READ_LATENCY-1 cycles with waitrequest=0.

Reset
REQ-030 SHALL, on reset_n=0 and regardless of clk, force these values:
- state=IDLE;
- read=0, address=0;
- value=0, valid=0, changed=0, busy=0;
- pending flag cleared;
- divider counter reloaded to POLL_DIV.
REQ-031 SHALL abandon a transaction when reset asserts mid-poll; no capture occurs.

Configuration
REQ-032 SHALL, with PIO_POLL_DEBOUNCE_EN defined, keep a raw-sample register of the previous capture.
- value updates only when the current sample equals that raw sample and differs from value.
- The first update requires two identical consecutive samples.
REQ-033 SHALL, without PIO_POLL_DEBOUNCE_EN, omit the raw-sample register and update per REQ-025.

Structure
REQ-034 SHALL place the FSM state enum and the default parameter constants in the shared package pio_poll_pkg.
REQ-035 SHALL contain one natural sub-module, poll_divider, holding the divider counter with reload and terminal-count output; the FSM stays in the top module.

Verification
REQ-036 SHALL cover reset then enable=1, POLL_DIV=8, readdata=0x5, waitrequest=0:
- read pulses every 8 cycles;
- first capture gives value=0x5, valid=1, changed pulsed once;
- the next identical poll leaves changed=0.
REQ-037 SHALL cover waitrequest=1 for 3 cycles during REQ: read is held 4 cycles and capture occurs READ_LATENCY cycles after the accepting edge.
REQ-038 SHALL cover READ_LATENCY=2 with readdata=0x3, then 0xA one cycle later: capture takes 0xA.
REQ-039 SHALL cover poll_now pulsed twice while busy: exactly one extra poll follows, and with enable=0 no further polls occur.
REQ-040 SHALL cover reset_n dropped during WAIT: read=0 and valid=0 immediately, with no changed pulse.
REQ-041 SHALL cover, with PIO_POLL_DEBOUNCE_EN, the sample sequence 0x1, 0x2, 0x2: value stays 0 after the first two polls and becomes 0x2 with changed pulsed on the third.

Source files
------------

// File: rtl/pio_poll_pkg.sv
// Shared types and default constants for the PIO polling master.
package pio_poll_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } poll_state_t;

  localparam int DEF_DATA_W       = 4;
  localparam int DEF_POLL_DIV     = 1000;
  localparam int DEF_READ_LATENCY = 1;
  localparam int DEF_POLL_ADDR    = 0;

endpackage

// File: rtl/poll_divider.sv
// Down-counter that paces automatic polls; tc holds at terminal count until reload.
module poll_divider
  import pio_poll_pkg::*;
#(
  parameter int POLL_DIV = DEF_POLL_DIV
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic reload,
  output logic tc
);

  localparam int CNT_W = $clog2(POLL_DIV + 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= CNT_W'(POLL_DIV);
    end else if (reload) begin
      cnt_q <= CNT_W'(POLL_DIV);
    end else if (enable && (cnt_q > CNT_W'(1))) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Terminal count is sticky, so a poll that falls due while busy starts once the FSM is idle.
  assign tc = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pio_poll_master.sv
// Avalon-MM master that periodically polls one slave word and tracks its low DATA_W bits.
// Optional build macro PIO_POLL_DEBOUNCE_EN: accept a sample only after two identical reads.
module pio_poll_master
  import pio_poll_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int POLL_DIV     = DEF_POLL_DIV,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int POLL_ADDR    = DEF_POLL_ADDR
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              poll_now,
  output logic [1:0]        address,
  output logic              read,
  input  logic              waitrequest,
  input  logic [31:0]       readdata,
  output logic [DATA_W-1:0] value,
  output logic              valid,
  output logic              changed,
  output logic              busy
);

  poll_state_t       state_q, state_d;
  logic [1:0]        wait_q, wait_d;
  logic              pending_q;
  logic              reload, tc, start, update;
  logic [DATA_W-1:0] sample;
  logic              unused_readdata;

  poll_divider #(.POLL_DIV(POLL_DIV)) u_divider (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .reload  (reload),
    .tc      (tc)
  );

  assign sample          = readdata[DATA_W-1:0];
  assign unused_readdata = &{1'b0, readdata};
  assign start           = poll_now | pending_q | (enable & tc);
  assign busy            = (state_q != IDLE);

`ifdef PIO_POLL_DEBOUNCE_EN
  logic [DATA_W-1:0] raw_q;
  logic              raw_valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raw_q       <= '0;
      raw_valid_q <= 1'b0;
    end else if (state_q == CAPTURE) begin
      raw_q       <= sample;
      raw_valid_q <= 1'b1;
    end
  end

  assign update = raw_valid_q && (sample == raw_q) && ((sample != value) || !valid);
`else
  assign update = (sample != value) || !valid;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    wait_d  = wait_q;
    reload  = 1'b0;
    read    = 1'b0;
    address = 2'd0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = REQ;
          reload  = 1'b1;
        end
      end
      REQ: begin
        read    = 1'b1;
        address = 2'(POLL_ADDR);
        if (!waitrequest) begin
          if (READ_LATENCY == 1) begin
            state_d = CAPTURE;
          end else begin
            state_d = WAIT;
            wait_d  = 2'(READ_LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (wait_q == 2'd0) state_d = CAPTURE;
        else                wait_d  = wait_q - 2'd1;
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every flop here carries real state, so all of them take the asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wait_q    <= 2'd0;
      pending_q <= 1'b0;
      value     <= '0;
      valid     <= 1'b0;
      changed   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      changed <= 1'b0;
      // IDLE always consumes the pending request, so only busy-time requests are remembered.
      if (state_q == IDLE)  pending_q <= 1'b0;
      else if (poll_now)    pending_q <= 1'b1;
      if ((state_q == CAPTURE) && update) begin
        value   <= sample;
        valid   <= 1'b1;
        changed <= 1'b1;
      end
    end
  end

endmodule
